// File: rtl/radio_cfg_pkg.sv
// Shared types and constants for the radio configuration sequencer.
package radio_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    FINISH
  } seq_state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [3:0]  WSTRB_ALL        = 4'hF;
  localparam int unsigned NUM_REGS_DEFAULT = 4;
  localparam int unsigned WORD_W           = 32;
  localparam int unsigned IDX_W            = 4;

endpackage

// File: rtl/axil_single_xfer.sv
// One AXI4-Lite write or read: drives request channels and accepts the response.
module axil_single_xfer
  import radio_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                go_i,
  input  logic                wr_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                req_done_c_o,
  output logic                rsp_done_c_o,
  output logic                rsp_err_c_o,
  output logic [DATA_W-1:0]   rdata_c_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic [2:0]          awprot_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic [2:0]          arprot_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rvalid_i,
  output logic                rready_o
);

  logic              awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              aw_pend_c, w_pend_c, wr_req_done_c, ar_fire_c, b_fire_c, r_fire_c;

  // A write request completes once neither AW nor W is still waiting after this cycle.
  assign aw_pend_c     = awvalid_q & ~awready_i;
  assign w_pend_c      = wvalid_q & ~wready_i;
  assign wr_req_done_c = (awvalid_q | wvalid_q) & ~aw_pend_c & ~w_pend_c;
  assign ar_fire_c     = arvalid_q & arready_i;
  assign b_fire_c      = bready_q & bvalid_i;
  assign r_fire_c      = rready_q & rvalid_i;

  assign req_done_c_o = wr_req_done_c | ar_fire_c;
  assign rsp_done_c_o = b_fire_c | r_fire_c;
  assign rsp_err_c_o  = (b_fire_c & (bresp_i != RESP_OKAY)) | (r_fire_c & (rresp_i != RESP_OKAY));
  assign rdata_c_o    = rdata_i;

  assign awaddr_o  = addr_q;
  assign araddr_o  = addr_q;
  assign awprot_o  = 3'b000;
  assign arprot_o  = 3'b000;
  assign awvalid_o = awvalid_q;
  assign wvalid_o  = wvalid_q;
  assign arvalid_o = arvalid_q;
  assign bready_o  = bready_q;
  assign rready_o  = rready_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = WSTRB_ALL;

  // Channel handshake tracking; each VALID drops the cycle after its own handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      if (awvalid_q && awready_i) awvalid_q <= 1'b0;
      if (wvalid_q && wready_i)   wvalid_q  <= 1'b0;
      if (ar_fire_c)              arvalid_q <= 1'b0;
      if (wr_req_done_c)          bready_q  <= 1'b1;
      if (ar_fire_c)              rready_q  <= 1'b1;
      if (b_fire_c)               bready_q  <= 1'b0;
      if (r_fire_c)               rready_q  <= 1'b0;
      if (go_i) begin
        addr_q <= addr_i;
        if (wr_i) begin
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          wdata_q   <= wdata_i;
        end else begin
          arvalid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/radio_cfg_sequencer.sv
// Writes NUM_REGS consecutive radio registers over AXI4-Lite, then reads them back and verifies.
module radio_cfg_sequencer
  import radio_cfg_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS           = NUM_REGS_DEFAULT
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   base_addr,
  input  logic [NUM_REGS*32-1:0]          cfg_wdata,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [3:0]                      err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned     AW       = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned     CFG_W    = NUM_REGS * WORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  seq_state_e       state_q;
  logic [IDX_W-1:0] idx_q, err_idx_q;
  logic [AW-1:0]    base_q;
  logic [CFG_W-1:0] cfg_q;
  logic             busy_q, done_q, error_q;

  logic             launch_c, launch_wr_c;
  logic [IDX_W-1:0] launch_idx_c;
  logic [AW-1:0]    launch_addr_c, base_sel_c, base_in_c;
  logic [CFG_W-1:0] cfg_sel_c;
  logic [WORD_W-1:0] launch_wdata_c, rdata_c;
  logic             req_done_c, rsp_done_c, rsp_err_c, is_last_c, rd_mismatch_c;

  assign base_in_c     = base_addr & ~AW'(3);
  assign is_last_c     = (idx_q == LAST_IDX);
  assign rd_mismatch_c = (rdata_c != cfg_q[WORD_W*32'(idx_q) +: WORD_W]);

  // Next transfer to hand to the bus engine, issued on the same edge the FSM enters a request state.
  always_comb begin
    launch_c     = 1'b0;
    launch_wr_c  = 1'b1;
    launch_idx_c = '0;
    base_sel_c   = base_q;
    cfg_sel_c    = cfg_q;
    case (state_q)
      IDLE: begin
        base_sel_c = base_in_c;
        cfg_sel_c  = cfg_wdata;
        launch_c   = start;
      end
      WR_RESP: begin
        if (rsp_done_c && !rsp_err_c) begin
          launch_c     = 1'b1;
          launch_wr_c  = !is_last_c;
          launch_idx_c = is_last_c ? '0 : idx_q + IDX_W'(1);
        end
      end
      RD_RESP: begin
        if (rsp_done_c && !rsp_err_c && !rd_mismatch_c && !is_last_c) begin
          launch_c     = 1'b1;
          launch_wr_c  = 1'b0;
          launch_idx_c = idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
    launch_addr_c  = base_sel_c + (AW'(launch_idx_c) << 2);
    launch_wdata_c = cfg_sel_c[WORD_W*32'(launch_idx_c) +: WORD_W];
  end

  // Sequencer FSM: register index, snapshot and status outputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      base_q    <= '0;
      cfg_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= WR_REQ;
            idx_q     <= '0;
            base_q    <= base_in_c;
            cfg_q     <= cfg_wdata;
            busy_q    <= 1'b1;
            error_q   <= 1'b0;
            err_idx_q <= '0;
          end
        end
        WR_REQ: if (req_done_c) state_q <= WR_RESP;
        WR_RESP: begin
          if (rsp_done_c) begin
            if (rsp_err_c) begin
              state_q   <= FINISH;
              done_q    <= 1'b1;
              error_q   <= 1'b1;
              err_idx_q <= idx_q;
            end else if (is_last_c) begin
              state_q <= RD_REQ;
              idx_q   <= '0;
            end else begin
              state_q <= WR_REQ;
              idx_q   <= idx_q + IDX_W'(1);
            end
          end
        end
        RD_REQ: if (req_done_c) state_q <= RD_RESP;
        RD_RESP: begin
          if (rsp_done_c) begin
            if (rsp_err_c || rd_mismatch_c) begin
              state_q   <= FINISH;
              done_q    <= 1'b1;
              error_q   <= 1'b1;
              err_idx_q <= idx_q;
            end else if (is_last_c) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= RD_REQ;
              idx_q   <= idx_q + IDX_W'(1);
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;
  assign err_idx = err_idx_q;

  axil_single_xfer #(
    .ADDR_W (AW),
    .DATA_W (C_M_AXI_DATA_WIDTH)
  ) u_xfer (
    .clk_i        (ACLK),
    .rst_i        (ARESET),
    .go_i         (launch_c),
    .wr_i         (launch_wr_c),
    .addr_i       (launch_addr_c),
    .wdata_i      (launch_wdata_c),
    .req_done_c_o (req_done_c),
    .rsp_done_c_o (rsp_done_c),
    .rsp_err_c_o  (rsp_err_c),
    .rdata_c_o    (rdata_c),
    .awaddr_o     (M_AXI_AWADDR),
    .awprot_o     (M_AXI_AWPROT),
    .awvalid_o    (M_AXI_AWVALID),
    .awready_i    (M_AXI_AWREADY),
    .wdata_o      (M_AXI_WDATA),
    .wstrb_o      (M_AXI_WSTRB),
    .wvalid_o     (M_AXI_WVALID),
    .wready_i     (M_AXI_WREADY),
    .bresp_i      (M_AXI_BRESP),
    .bvalid_i     (M_AXI_BVALID),
    .bready_o     (M_AXI_BREADY),
    .araddr_o     (M_AXI_ARADDR),
    .arprot_o     (M_AXI_ARPROT),
    .arvalid_o    (M_AXI_ARVALID),
    .arready_i    (M_AXI_ARREADY),
    .rdata_i      (M_AXI_RDATA),
    .rresp_i      (M_AXI_RRESP),
    .rvalid_i     (M_AXI_RVALID),
    .rready_o     (M_AXI_RREADY)
  );

endmodule

// File: tb/tb_radio_cfg_sequencer.sv
// Directed bench for radio_cfg_sequencer with a small configurable AXI4-Lite slave model.
module tb_radio_cfg_sequencer;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic         start;
  logic [31:0]  base_addr;
  logic [127:0] cfg_wdata;
  logic         busy, done, error;
  logic [3:0]   err_idx;
  logic [31:0]  M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]   M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]   M_AXI_WSTRB;
  logic         M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic         M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic         M_AXI_RVALID, M_AXI_RREADY;
  logic [1:0]   M_AXI_BRESP, M_AXI_RRESP;

  int total = 0;
  int bad   = 0;

  radio_cfg_sequencer dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .base_addr(base_addr), .cfg_wdata(cfg_wdata),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  // ---------------- slave model ----------------
  int          aw_delay = 0;
  bit          berr_en = 1'b0, stuck_en = 1'b0;
  logic [3:0]  berr_reg = 4'd0, stuck_reg = 4'd0;
  int          aw_wait;
  logic        aw_got, w_got;
  logic [31:0] aw_a, w_d;
  logic [31:0] mem [0:15];
  logic [31:0] aw_log [0:127];
  logic [31:0] w_log  [0:127];
  logic [31:0] ar_log [0:127];
  int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, aw_vcyc = 0, w_vcyc = 0, bad_side = 0;
  logic        aw_hs_c, w_hs_c, wr_fire_c;
  logic [31:0] wr_addr_c, wr_data_c;

  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= aw_delay);
  assign M_AXI_WREADY  = 1'b1;
  assign M_AXI_ARREADY = 1'b1;
  assign aw_hs_c   = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs_c    = M_AXI_WVALID && M_AXI_WREADY;
  assign wr_addr_c = aw_hs_c ? M_AXI_AWADDR : aw_a;
  assign wr_data_c = w_hs_c ? M_AXI_WDATA : w_d;
  assign wr_fire_c = (aw_got || aw_hs_c) && (w_got || w_hs_c) && !M_AXI_BVALID;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
      M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= 32'h0;
    end else begin
      if (M_AXI_AWVALID) aw_vcyc <= aw_vcyc + 1;
      if (M_AXI_WVALID)  w_vcyc  <= w_vcyc + 1;
      if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_wait <= aw_wait + 1;
      if (aw_hs_c) begin
        aw_wait <= 0; aw_got <= 1'b1; aw_a <= M_AXI_AWADDR;
        aw_log[aw_n] <= M_AXI_AWADDR; aw_n <= aw_n + 1;
        if (M_AXI_AWPROT != 3'b000) bad_side <= bad_side + 1;
      end
      if (w_hs_c) begin
        w_got <= 1'b1; w_d <= M_AXI_WDATA;
        w_log[w_n] <= M_AXI_WDATA; w_n <= w_n + 1;
        if (M_AXI_WSTRB != 4'hF) bad_side <= bad_side + 1;
      end
      if (wr_fire_c) begin
        mem[wr_addr_c[5:2]] <= (stuck_en && wr_addr_c[5:2] == stuck_reg) ? 32'h0 : wr_data_c;
        M_AXI_BVALID <= 1'b1;
        M_AXI_BRESP  <= (berr_en && wr_addr_c[5:2] == berr_reg) ? 2'b10 : 2'b00;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        M_AXI_BVALID <= 1'b0; b_n <= b_n + 1;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        M_AXI_RVALID <= 1'b1; M_AXI_RDATA <= mem[M_AXI_ARADDR[5:2]]; M_AXI_RRESP <= 2'b00;
        ar_log[ar_n] <= M_AXI_ARADDR; ar_n <= ar_n + 1;
        if (M_AXI_ARPROT != 3'b000) bad_side <= bad_side + 1;
      end else if (M_AXI_RVALID && M_AXI_RREADY) begin
        M_AXI_RVALID <= 1'b0;
      end
    end
  end

  // ---------------- tasks ----------------
  // Start one pass, scramble the inputs afterwards, return the 1-based cycle of done (0 = timeout).
  task automatic run_pass(input logic [31:0] base, input logic [127:0] cfg, output int lat);
    @(negedge ACLK);
    base_addr = base; cfg_wdata = cfg; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0; base_addr = ~base; cfg_wdata = ~cfg;
    lat = 0;
    for (int k = 0; k < 200; k++) begin
      if (done) begin lat = k + 2; break; end
      @(negedge ACLK);
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1; start = 1'b0; base_addr = 32'h0; cfg_wdata = '0;
    repeat (3) @(negedge ACLK);
    total++;
    if ({busy, done, error, err_idx} !== 7'b0) begin
      bad++; $display("FAIL reset_status: got %b want 0000000", {busy, done, error, err_idx});
    end
    total++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY} !== 5'b0) begin
      bad++; $display("FAIL reset_axi: got %b want 00000",
                      {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY});
    end
    ARESET = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic test_basic();
    int lat, aw0, ar0, w0;
    aw0 = aw_n; ar0 = ar_n; w0 = w_n;
    run_pass(32'h0, {32'd4, 32'd3, 32'd2, 32'd1}, lat);
    total++; if (lat !== 18) begin bad++; $display("FAIL basic_latency: got %0d want 18", lat); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL basic_error: got %b want 0", error); end
    total++; if (aw_n - aw0 !== 4) begin bad++; $display("FAIL basic_aw_count: got %0d want 4", aw_n - aw0); end
    total++; if (ar_n - ar0 !== 4) begin bad++; $display("FAIL basic_ar_count: got %0d want 4", ar_n - ar0); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (aw_log[aw0+k] !== 32'(4*k)) begin
        bad++; $display("FAIL basic_awaddr%0d: got %h want %h", k, aw_log[aw0+k], 32'(4*k));
      end
      total++;
      if (w_log[w0+k] !== 32'(k+1)) begin
        bad++; $display("FAIL basic_wdata%0d: got %h want %h", k, w_log[w0+k], 32'(k+1));
      end
      total++;
      if (ar_log[ar0+k] !== 32'(4*k)) begin
        bad++; $display("FAIL basic_araddr%0d: got %h want %h", k, ar_log[ar0+k], 32'(4*k));
      end
    end
    @(negedge ACLK);
    total++;
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL basic_done_pulse: got %b want 00", {done, busy}); end
  endtask

  task automatic test_aw_delay();
    int lat, awv0, wv0, b0;
    aw_delay = 2; awv0 = aw_vcyc; wv0 = w_vcyc; b0 = b_n;
    run_pass(32'h0, {32'hDEAD0004, 32'hBEEF0003, 32'hCAFE0002, 32'hF00D0001}, lat);
    aw_delay = 0;
    total++; if (lat !== 26) begin bad++; $display("FAIL awdly_latency: got %0d want 26", lat); end
    total++; if (aw_vcyc - awv0 !== 12) begin bad++; $display("FAIL awdly_awvalid_cycles: got %0d want 12", aw_vcyc - awv0); end
    total++; if (w_vcyc - wv0 !== 4) begin bad++; $display("FAIL awdly_wvalid_cycles: got %0d want 4", w_vcyc - wv0); end
    total++; if (b_n - b0 !== 4) begin bad++; $display("FAIL awdly_b_count: got %0d want 4", b_n - b0); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL awdly_error: got %b want 0", error); end
  endtask

  task automatic test_bresp_err();
    int lat, aw0, ar0;
    berr_en = 1'b1; berr_reg = 4'd2; aw0 = aw_n; ar0 = ar_n;
    run_pass(32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL berr_latency: got %0d want 8", lat); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL berr_error: got %b want 1", error); end
    total++; if (err_idx !== 4'd2) begin bad++; $display("FAIL berr_idx: got %0d want 2", err_idx); end
    repeat (4) @(negedge ACLK);
    berr_en = 1'b0;
    total++; if (error !== 1'b1) begin bad++; $display("FAIL berr_error_held: got %b want 1", error); end
    total++; if (aw_n - aw0 !== 3) begin bad++; $display("FAIL berr_aw_count: got %0d want 3", aw_n - aw0); end
    total++; if (ar_n - ar0 !== 0) begin bad++; $display("FAIL berr_ar_count: got %0d want 0", ar_n - ar0); end
  endtask

  task automatic test_readback();
    int lat, ar0;
    stuck_en = 1'b1; stuck_reg = 4'd1; ar0 = ar_n;
    run_pass(32'h0, {32'h40, 32'h30, 32'h2, 32'h10}, lat);
    stuck_en = 1'b0;
    total++; if (lat !== 14) begin bad++; $display("FAIL rdbk_latency: got %0d want 14", lat); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL rdbk_error: got %b want 1", error); end
    total++; if (err_idx !== 4'd1) begin bad++; $display("FAIL rdbk_idx: got %0d want 1", err_idx); end
    total++; if (ar_n - ar0 !== 2) begin bad++; $display("FAIL rdbk_ar_count: got %0d want 2", ar_n - ar0); end
  endtask

  task automatic test_busy_reset();
    int n, aw0, dones;
    aw0 = aw_n;
    @(negedge ACLK);
    base_addr = 32'h100; cfg_wdata = {32'h8, 32'h7, 32'h6, 32'h5}; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", busy); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL error_cleared_on_start: got %b want 0", error); end
    repeat (4) @(negedge ACLK);
    start = 1'b1; base_addr = 32'h200;
    @(negedge ACLK);
    start = 1'b0;
    n = 5;
    while (!done && n < 200) begin @(negedge ACLK); n++; end
    total++; if (n + 2 !== 18) begin bad++; $display("FAIL ignored_start_latency: got %0d want 18", n + 2); end
    repeat (5) @(negedge ACLK);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignored_start_idle: got %b want 0", busy); end
    total++; if (aw_n - aw0 !== 4) begin bad++; $display("FAIL ignored_start_aw_count: got %0d want 4", aw_n - aw0); end
    total++; if (aw_log[aw0] !== 32'h100) begin bad++; $display("FAIL ignored_start_addr: got %h want 00000100", aw_log[aw0]); end
    // second pass: reset while waiting for the first write response
    @(negedge ACLK);
    base_addr = 32'h0; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    @(negedge ACLK);
    total++; if (M_AXI_BREADY !== 1'b1) begin bad++; $display("FAIL midreset_in_wr_resp: got %b want 1", M_AXI_BREADY); end
    ARESET = 1'b1;
    #1;
    total++;
    if ({busy, done, error, err_idx, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY} !== 12'b0) begin
      bad++; $display("FAIL midreset_clear: got %b want 0", {busy, done, error, err_idx, M_AXI_AWVALID,
                      M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY});
    end
    @(negedge ACLK);
    ARESET = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin @(negedge ACLK); if (done) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL midreset_no_done: got %0d want 0", dones); end
  endtask

  task automatic test_wrap();
    int lat, aw0, ar0;
    logic [31:0] exp_a [4];
    exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    aw0 = aw_n; ar0 = ar_n;
    run_pass(32'hFFFF_FFFB, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, lat);
    total++; if (lat !== 18) begin bad++; $display("FAIL wrap_latency: got %0d want 18", lat); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL wrap_error: got %b want 0", error); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (aw_log[aw0+k] !== exp_a[k]) begin
        bad++; $display("FAIL wrap_awaddr%0d: got %h want %h", k, aw_log[aw0+k], exp_a[k]);
      end
      total++;
      if (ar_log[ar0+k] !== exp_a[k]) begin
        bad++; $display("FAIL wrap_araddr%0d: got %h want %h", k, ar_log[ar0+k], exp_a[k]);
      end
    end
    total++; if (bad_side !== 0) begin bad++; $display("FAIL prot_strb: got %0d bad beats want 0", bad_side); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_delay();
    test_bresp_err();
    test_readback();
    test_busy_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
